// File: rtl/hashing_functions.sv
// rtl/hashing_functions.sv - SHA-2 word types, schedule constants and small-sigma functions
package hashing_functions;

  localparam int data_width  = 32;
  localparam int SCHED_WORDS = 64;
  localparam int BLOCK_WORDS = 16;

  typedef logic [data_width-1:0] word_t;

  typedef enum logic {LOAD, EXPAND} sched_state_t;

  // sigma0: rotr7 ^ rotr18 ^ shr3
  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: rotr17 ^ rotr19 ^ shr10
  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_message_scheduler.sv
// rtl/sha2_message_scheduler.sv - streaming SHA-256 schedule W0..W63 from 16 message words
// Optional framing check (data_in_last, sync_err) under SHA2_SCHED_LAST_CHECK_EN.
module sha2_message_scheduler
  import hashing_functions::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        data_out_last
`ifdef SHA2_SCHED_LAST_CHECK_EN
  ,
  input  logic        data_in_last,
  output logic        sync_err
`endif
);

  sched_state_t state, next_state;
  logic [5:0]   t;
  word_t        w [BLOCK_WORDS];
  word_t        w_new, next_word;
  logic         advance, load, gen, step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  always_comb begin
    advance       = !data_out_valid || data_out_ready;
    data_in_ready = 1'b0;
    load          = 1'b0;
    gen           = 1'b0;
    next_state    = state;
    case (state)
      LOAD: begin
        data_in_ready = advance;
        load          = data_in_valid && advance;
        if (load && t == 6'(BLOCK_WORDS - 1)) next_state = EXPAND;
      end
      EXPAND: begin
        gen = advance;
        if (gen && t == 6'(SCHED_WORDS - 1)) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  // w[14], w[9], w[1], w[0] hold W(t-2), W(t-7), W(t-15), W(t-16)
  assign w_new     = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  assign next_word = load ? data_in : w_new;
  assign step      = load || gen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) w[i] <= '0;
      t              <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) w[i] <= w[i+1];
      w[BLOCK_WORDS-1] <= next_word;
      data_out         <= next_word;
      data_out_valid   <= 1'b1;
      data_out_last    <= (t == 6'(SCHED_WORDS - 1));
      t                <= t + 6'd1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end
  end

`ifdef SHA2_SCHED_LAST_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sync_err <= 1'b0;
    else if (load && (data_in_last != (t == 6'(BLOCK_WORDS - 1))))
      sync_err <= 1'b1;
  end
`endif

endmodule
